// File: rtl/output_packer.sv
// output_packer
//   Packs PACK consecutive output channels of one pixel, as streamed by the
//   conv core (no back-pressure), into one wide word. Words are queued in a
//   small FIFO and presented on a valid/ready stream together with their word
//   address in the output memory. Lost words and broken lane order are
//   reported through sticky flags rather than being hidden.
//
// Ports
//   clk, arst_n   clock, asynchronous active-low reset
//   in_data       signed element from the core
//   in_valid      element strobe (no ready: the core cannot be stalled)
//   in_x/in_y     pixel column / row of the element
//   in_ch         output channel of the element
//   out_data      packed word, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//   out_addr      word address of out_data
//   out_valid     FIFO head valid
//   out_ready     sink accepts the head when out_valid & out_ready
//   overflow      sticky: a completed word was dropped on a full FIFO
//   seq_err       sticky: an element arrived out of lane order
//   busy          a partial word is held or the FIFO is non-empty

// One lane holding register of the word being assembled.
module output_packer_lane #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)  q <= '0;
        else if (we)  q <= d;
    end
endmodule

module output_packer #(
    parameter int DATA_WIDTH         = 16,
    parameter int PACK               = 4,
    parameter int FIFO_DEPTH         = 4,
    parameter int FEATURE_MAP_WIDTH  = 128,
    parameter int FEATURE_MAP_HEIGHT = 128,
    parameter int OUTPUT_NB_CHANNELS = 64,
    parameter int ADDR_WIDTH         =
        $clog2(FEATURE_MAP_WIDTH*FEATURE_MAP_HEIGHT*OUTPUT_NB_CHANNELS/PACK)
) (
    input  logic                                  clk,
    input  logic                                  arst_n,
    input  logic signed [DATA_WIDTH-1:0]          in_data,
    input  logic                                  in_valid,
    input  logic [$clog2(FEATURE_MAP_WIDTH)-1:0]  in_x,
    input  logic [$clog2(FEATURE_MAP_HEIGHT)-1:0] in_y,
    input  logic [$clog2(OUTPUT_NB_CHANNELS)-1:0] in_ch,
    output logic [PACK*DATA_WIDTH-1:0]            out_data,
    output logic [ADDR_WIDTH-1:0]                 out_addr,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic                                  overflow,
    output logic                                  seq_err,
    output logic                                  busy
);
    localparam int LANE_W        = $clog2(PACK);
    localparam int FW            = $clog2(FIFO_DEPTH);
    localparam int WORDS_PER_PIX = OUTPUT_NB_CHANNELS / PACK;

    // ------------------------------------------------------------------
    // Lane tracking
    // ------------------------------------------------------------------
    logic [LANE_W-1:0] lane;
    logic [LANE_W-1:0] exp_lane;
    logic              match;
    logic              last;

    assign lane  = in_ch[LANE_W-1:0];
    assign match = in_valid && (lane == exp_lane);
    assign last  = match && (exp_lane == LANE_W'(PACK-1));

    // Lanes 0..PACK-2 are registered; the final lane goes straight into the
    // FIFO on the completing edge, so it never needs a holding register.
    logic [PACK-2:0][DATA_WIDTH-1:0] lane_q;
    logic [PACK-2:0]                 lane_we;

    for (genvar k = 0; k < PACK-1; k++) begin : g_lane
        // Lane 0 is always written on a lane-0 strobe: either it is the
        // expected lane, or it restarts a word after an order violation.
        assign lane_we[k] = in_valid && (lane == LANE_W'(k)) && (match || k == 0);

        output_packer_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
            .clk    (clk),
            .arst_n (arst_n),
            .we     (lane_we[k]),
            .d      (in_data),
            .q      (lane_q[k])
        );
    end

    logic [PACK*DATA_WIDTH-1:0] push_word;

    for (genvar k = 0; k < PACK; k++) begin : g_word
        if (k == PACK-1) begin : g_tail
            assign push_word[k*DATA_WIDTH +: DATA_WIDTH] = in_data;
        end else begin : g_held
            assign push_word[k*DATA_WIDTH +: DATA_WIDTH] = lane_q[k];
        end
    end

    // Word address, taken from the lane-0 element only. All terms are
    // widened to ADDR_WIDTH before the arithmetic so nothing is truncated.
    logic [ADDR_WIDTH-1:0] addr_calc;
    logic [ADDR_WIDTH-1:0] word_addr;

    assign addr_calc = (ADDR_WIDTH'(in_y) * ADDR_WIDTH'(FEATURE_MAP_WIDTH) + ADDR_WIDTH'(in_x))
                     * ADDR_WIDTH'(WORDS_PER_PIX) + ADDR_WIDTH'(in_ch >> LANE_W);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            exp_lane  <= '0;
            word_addr <= '0;
            seq_err   <= 1'b0;
        end else if (in_valid) begin
            if (!match)
                seq_err <= 1'b1;
            if (lane == '0) begin
                // Lane 0 always (re)starts a word, in or out of order.
                exp_lane  <= LANE_W'(1);
                word_addr <= addr_calc;
            end else if (match) begin
                // PACK is a power of two, so PACK-1 wraps back to 0 here.
                exp_lane  <= exp_lane + 1'b1;
            end else begin
                exp_lane  <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Packed-word FIFO
    // ------------------------------------------------------------------
    logic [PACK*DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]      mem_addr [FIFO_DEPTH];
    logic [FW-1:0]              wptr;
    logic [FW-1:0]              rptr;
    logic [FW:0]                count;
    logic                       empty;
    logic                       full;
    logic                       pop;
    logic                       wr;

    assign empty = (count == '0);
    assign full  = (count == (FW+1)'(FIFO_DEPTH));
    assign pop   = !empty && out_ready;
    // A full FIFO still takes a word when its head leaves the same edge.
    assign wr    = last && (!full || pop);

    always_ff @(posedge clk) begin
        if (wr) begin
            mem_data[wptr] <= push_word;
            mem_addr[wptr] <= word_addr;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (last && full && !pop)
                overflow <= 1'b1;
            // Pointers wrap naturally since FIFO_DEPTH is a power of two.
            if (wr)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            case ({wr, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Head is gated by !empty so the stream reads as zero whenever nothing
    // is queued (including straight out of reset, when memory is stale).
    assign out_valid = !empty;
    assign out_data  = empty ? '0 : mem_data[rptr];
    assign out_addr  = empty ? '0 : mem_addr[rptr];
    assign busy      = (exp_lane != '0) || !empty;

endmodule
